// File: rtl/sar_scan_ctl.sv
// SAR-ADC scan controller: walks the enabled comparator-mux channels round-robin,
// binary-searches a DW-bit code per channel and returns it over a valid/ready port.
module sar_scan_ctl #(
    parameter int unsigned NCH   = 16,
    parameter int unsigned DW    = 10,
    parameter int unsigned T_SMP = 8,
    parameter int unsigned T_BIT = 4
) (
    input  logic           clk,
    input  logic           srst,
    input  logic           scan_en,
    input  logic [NCH-1:0] ch_mask,
    input  logic           comp_o,
    output logic           dac1_en,
    output logic [DW-1:0]  dac1,
    output logic [NCH-1:0] cmp_sel,
    output logic           ad_rst,
    output logic           ad_hold,
    output logic           res_vld,
    input  logic           res_rdy,
    output logic [DW-1:0]  res_dat,
    output logic [3:0]     res_ch,
    output logic           busy
);

    localparam int unsigned CntMax = (T_SMP > T_BIT) ? T_SMP : T_BIT;
    localparam int unsigned CntW   = (CntMax > 1) ? $clog2(CntMax) : 1;
    localparam int unsigned BitW   = (DW > 1) ? $clog2(DW) : 1;

    typedef enum logic [2:0] {
        StIdle,
        StSmp,
        StHld,
        StCnv,
        StDone
    } state_e;

    state_e          state_q, state_d;
    logic [3:0]      ptr_q, ptr_d;
    logic [3:0]      ch_q, ch_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [DW-1:0]   trial_q, trial_d;
    logic [BitW-1:0] bit_q, bit_d;
    logic [DW-1:0]   res_dat_q, res_dat_d;
    logic [3:0]      res_ch_q, res_ch_d;

    logic            comp_meta_q, comp_s_q;

    logic            pick_found;
    logic [3:0]      pick_ch;

    logic            dac1_en_q, dac1_en_d;
    logic [DW-1:0]   dac1_q, dac1_d;
    logic [NCH-1:0]  cmp_sel_q, cmp_sel_d;
    logic            ad_rst_q, ad_rst_d;
    logic            ad_hold_q, ad_hold_d;
    logic            res_vld_q, res_vld_d;
    logic            busy_q, busy_d;

    // comp_o is asynchronous to clk.
    always_ff @(posedge clk) begin
        if (srst) begin
            comp_meta_q <= 1'b0;
            comp_s_q    <= 1'b0;
        end else begin
            comp_meta_q <= comp_o;
            comp_s_q    <= comp_meta_q;
        end
    end

    // First enabled channel at or after ptr, wrapping modulo NCH.
    always_comb begin
        logic [4:0] sum;
        logic [3:0] idx;
        pick_found = 1'b0;
        pick_ch    = '0;
        for (int i = 0; i < int'(NCH); i++) begin
            sum = {1'b0, ptr_q} + 5'(i);
            if (sum >= 5'(NCH)) begin
                sum = sum - 5'(NCH);
            end
            idx = sum[3:0];
            if (!pick_found && ch_mask[idx]) begin
                pick_found = 1'b1;
                pick_ch    = idx;
            end
        end
    end

    always_comb begin
        logic [DW-1:0] t;
        state_d   = state_q;
        ptr_d     = ptr_q;
        ch_d      = ch_q;
        cnt_d     = cnt_q;
        trial_d   = trial_q;
        bit_d     = bit_q;
        res_dat_d = res_dat_q;
        res_ch_d  = res_ch_q;
        t         = trial_q;

        unique case (state_q)
            StIdle: begin
                if (scan_en && pick_found) begin
                    ch_d    = pick_ch;
                    cnt_d   = '0;
                    trial_d = '0;
                    state_d = StSmp;
                end
            end
            StSmp: begin
                if (!scan_en) begin
                    state_d = StIdle;
                end else if (cnt_q == CntW'(T_SMP - 1)) begin
                    cnt_d   = '0;
                    state_d = StHld;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StHld: begin
                if (!scan_en) begin
                    state_d = StIdle;
                end else begin
                    trial_d = {1'b1, {(DW - 1){1'b0}}};
                    bit_d   = BitW'(DW - 1);
                    cnt_d   = '0;
                    state_d = StCnv;
                end
            end
            StCnv: begin
                if (!scan_en) begin
                    state_d = StIdle;
                end else if (cnt_q == CntW'(T_BIT - 1)) begin
                    // Decide on the last cycle of the window so comp_s has settled.
                    cnt_d = '0;
                    if (!comp_s_q) begin
                        t[bit_q] = 1'b0;
                    end
                    if (bit_q != '0) begin
                        t[bit_q - 1'b1] = 1'b1;
                        bit_d           = bit_q - 1'b1;
                    end else begin
                        res_dat_d = t;
                        res_ch_d  = ch_q;
                        state_d   = StDone;
                    end
                    trial_d = t;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StDone: begin
                if (res_rdy) begin
                    ptr_d   = (ch_q == 4'(NCH - 1)) ? 4'd0 : ch_q + 4'd1;
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Analog-facing outputs are registered from next-state so they never glitch.
    always_comb begin
        dac1_en_d = 1'b0;
        dac1_d    = '0;
        cmp_sel_d = '0;
        ad_rst_d  = 1'b0;
        ad_hold_d = 1'b0;
        res_vld_d = 1'b0;
        busy_d    = (state_d != StIdle);

        unique case (state_d)
            StSmp: begin
                cmp_sel_d = NCH'(1) << ch_d;
                dac1_en_d = 1'b1;
                ad_rst_d  = 1'b1;
            end
            StHld: begin
                cmp_sel_d = NCH'(1) << ch_d;
                dac1_en_d = 1'b1;
                ad_hold_d = 1'b1;
            end
            StCnv: begin
                cmp_sel_d = NCH'(1) << ch_d;
                dac1_en_d = 1'b1;
                ad_hold_d = 1'b1;
                dac1_d    = trial_d;
            end
            StDone: begin
                cmp_sel_d = NCH'(1) << ch_d;
                dac1_en_d = 1'b1;
                ad_hold_d = 1'b1;
                dac1_d    = trial_d;
                res_vld_d = 1'b1;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            state_q   <= StIdle;
            ptr_q     <= '0;
            ch_q      <= '0;
            cnt_q     <= '0;
            trial_q   <= '0;
            bit_q     <= '0;
            res_dat_q <= '0;
            res_ch_q  <= '0;
            dac1_en_q <= 1'b0;
            dac1_q    <= '0;
            cmp_sel_q <= '0;
            ad_rst_q  <= 1'b0;
            ad_hold_q <= 1'b0;
            res_vld_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            ch_q      <= ch_d;
            cnt_q     <= cnt_d;
            trial_q   <= trial_d;
            bit_q     <= bit_d;
            res_dat_q <= res_dat_d;
            res_ch_q  <= res_ch_d;
            dac1_en_q <= dac1_en_d;
            dac1_q    <= dac1_d;
            cmp_sel_q <= cmp_sel_d;
            ad_rst_q  <= ad_rst_d;
            ad_hold_q <= ad_hold_d;
            res_vld_q <= res_vld_d;
            busy_q    <= busy_d;
        end
    end

    assign dac1_en = dac1_en_q;
    assign dac1    = dac1_q;
    assign cmp_sel = cmp_sel_q;
    assign ad_rst  = ad_rst_q;
    assign ad_hold = ad_hold_q;
    assign res_vld = res_vld_q;
    assign res_dat = res_dat_q;
    assign res_ch  = res_ch_q;
    assign busy    = busy_q;

    // The analog mux and S/H must never see overlapping selects or track/hold.
    a_sel_onehot0: assert property (@(posedge clk) $onehot0(cmp_sel));
    a_rst_hold_excl: assert property (@(posedge clk) !(ad_rst && ad_hold));

endmodule
